fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
PC register and instruction-fetch sequencer that sits directly downstream of the branch/next-PC multiplexer and upstream of decode.
- Holds the architectural PC and issues one request per instruction to instruction memory over a valid/ready request channel.
- Captures the response and presents instruction plus PC to decode.
- Loads `pc_next` (from the branch mux) when decode consumes the instruction.
- One instruction in flight at a time (multi-cycle core).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction (addi x0,x0,0) substituted on misaligned fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_next  in  32  next PC from branch mux; sampled only on consume.
- imem_req_valid  out  1  instruction-memory request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  word-aligned request address.
- imem_rsp_valid  in  1  response data valid, single-cycle pulse.
- imem_rsp_data  in  32  fetched instruction word.
- pc  out  32  PC of presented instruction (feeds branch mux `pc` and target adders).
- inst  out  32  presented instruction.
- inst_valid  out  1  inst/pc valid for decode.
- inst_ready  in  1  decode/execute consumes instruction this cycle.
- inst_misaligned  out  1  presented PC has pc[1:0]!=0; qualified by inst_valid.

Behaviour:
- Reset (async assert, any state): pc=RESET_PC, inst=NOP_INST, inst_valid=0, inst_misaligned=0, imem_req_valid=0, imem_addr=0, state=BOOT. An in-flight request is abandoned; a late response is ignored.
- FSM states: BOOT, REQ, WAIT, HOLD.
- BOOT: one cycle after reset release, then go to REQ.
- REQ:
  - imem_req_valid=1, imem_addr={pc[31:2],2'b00}, held stable until imem_req_ready.
  - On valid&ready: go to WAIT.
  - imem_rsp_valid in REQ is ignored.
  - If pc[1:0]!=0 on REQ entry: no request issued; inst<=NOP_INST, inst_misaligned<=1, inst_valid<=1, go directly to HOLD.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid: inst<=imem_rsp_data, inst_valid<=1, inst_misaligned<=0, go to HOLD.
  - Minimum fetch latency: accept edge to inst_valid = 1 cycle after the response edge, i.e. inst_valid rises the cycle after imem_rsp_valid.
  - No timeout; stays in WAIT indefinitely.
- HOLD:
  - inst/pc/inst_misaligned stable while inst_valid=1 and inst_ready=0.
  - On inst_ready: pc<=pc_next (full 32 bits, no masking), inst_valid<=0, go to REQ.
  - pc_next is sampled only on this edge; changes at other times have no effect.
- inst_ready outside HOLD is ignored, so no PC update occurs.
- Back-to-back throughput: consume edge → REQ next cycle; a zero-wait memory gives 3 cycles per instruction minimum (REQ, WAIT, HOLD).
- pc wraps modulo 2^32 (0xFFFF_FFFC + 4 from the mux yields 0); no special handling.
- Misaligned PC is flagged, not trapped here; the exception unit uses inst_misaligned to vector via mtvec.
- All outputs registered or decoded from state only; no combinational path from any input to any output.

Decomposition:
- Shared core package: enum fetch_state_t {BOOT, REQ, WAIT, HOLD}; constants RESET_PC_DEFAULT and NOP_INST (addi x0,x0,0), reused by decode and pipeline-bubble logic.
- No sub-module; single module with one state register block and one output/next-state block.

Test Plan:
- Reset then zero-wait memory returning 0x00500093 → imem_addr=0x0 in REQ; inst_valid=1 with inst=0x00500093, pc=0x0; after inst_ready with pc_next=0x4, next imem_addr=0x4.
- Memory holds imem_req_ready=0 for 5 cycles → imem_req_valid and imem_addr=0x4 stable for all 5 cycles; exactly one handshake.
- Decode holds inst_ready=0 for 4 cycles while pc_next toggles 0x100/0x200 → inst, pc unchanged; on consume with pc_next=0x200, next fetch address is 0x200.
- Branch redirect: consume with pc_next=0x80000000 (mtvec) → pc=0x80000000, request to 0x80000000.
- pc_next=0x102 on consume → no request; inst=0x00000013, inst_misaligned=1, pc=0x102.
- rst_n asserted during WAIT, then a stale imem_rsp_valid arrives in BOOT/REQ → ignored; pc=RESET_PC; first valid instruction comes from the post-reset request.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared core definitions: fetch sequencer states, reset PC and the canonical NOP,
// also used by decode and pipeline-bubble logic.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013; // addi x0,x0,0

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// PC register and single-outstanding instruction-fetch sequencer between the
// next-PC mux and decode. All outputs are registered.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = fetch_unit_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = fetch_unit_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_next,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        inst_misaligned
);

  import fetch_unit_pkg::*;

  fetch_state_t state;

  // The request is set up on the edge that enters REQ, so a misaligned PC
  // never raises imem_req_valid; REQ then substitutes the NOP and goes to HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= BOOT;
      pc              <= RESET_PC;
      inst            <= NOP_INST;
      inst_valid      <= 1'b0;
      inst_misaligned <= 1'b0;
      imem_req_valid  <= 1'b0;
      imem_addr       <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          imem_req_valid <= is_aligned(pc[1:0]);
          imem_addr      <= word_addr(pc);
          state          <= REQ;
        end
        REQ: begin
          if (!is_aligned(pc[1:0])) begin
            inst            <= NOP_INST;
            inst_misaligned <= 1'b1;
            inst_valid      <= 1'b1;
            state           <= HOLD;
          end else if (imem_req_ready) begin
            imem_req_valid <= 1'b0;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            inst            <= imem_rsp_data;
            inst_misaligned <= 1'b0;
            inst_valid      <= 1'b1;
            state           <= HOLD;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            pc             <= pc_next;
            inst_valid     <= 1'b0;
            imem_req_valid <= is_aligned(pc_next[1:0]);
            imem_addr      <= word_addr(pc_next);
            state          <= REQ;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: reactive memory/decode models with random
// timing, a transaction-level reference checked every cycle, and directed cases.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_next = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        inst_misaligned;

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .pc_next(pc_next),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .pc(pc), .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_misaligned(inst_misaligned)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h5A5A_0F0F);
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  logic [31:0] m_pc;
  int unsigned m_hs, m_since, post_rst;
  logic        m_await, rsp_ok, cons, aligned;
  logic        p_consume, p_req_v, p_req_r, p_iv, p_ir, p_rsp_ok;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pc = RST_PC; m_hs = 0; m_since = 0; post_rst = 0; m_await = 1'b0;
      p_consume = 1'b0; p_req_v = 1'b0; p_req_r = 1'b0;
      p_iv = 1'b0; p_ir = 1'b0; p_rsp_ok = 1'b0;
    end else begin
      post_rst++;
      m_since++;
      aligned = (m_pc[1:0] == 2'b00);
      if (post_rst == 1) begin
        chk("boot_no_req", imem_req_valid, 1'b0);
        chk("boot_no_inst", inst_valid, 1'b0);
      end
      if (post_rst == 2) chk("boot_then_req", imem_req_valid, 1'b1);
      if (p_consume) begin
        chk("consume_drops_valid", inst_valid, 1'b0);
        chk("req_after_consume", imem_req_valid, aligned);
      end
      if (p_req_v && !p_req_r) chk("req_held_until_ready", imem_req_valid, 1'b1);
      if (imem_req_valid) begin
        chk("req_addr", imem_addr, m_pc & 32'hFFFF_FFFC);
        chk("req_not_while_presenting", inst_valid, 1'b0);
      end
      rsp_ok = m_await && imem_rsp_valid;
      if (rsp_ok) m_await = 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        m_hs++;
        m_await = 1'b1;
      end
      if (p_rsp_ok) chk("rsp_to_valid_latency", inst_valid, 1'b1);
      if (inst_valid && !p_iv) begin
        if (aligned) begin
          chk("one_handshake", m_hs, 1);
          chk("valid_only_after_rsp", p_rsp_ok, 1'b1);
        end else begin
          chk("misaligned_no_req", m_hs, 0);
          chk("misaligned_latency", m_since, 2);
        end
      end
      if (p_iv && !p_ir) chk("valid_held", inst_valid, 1'b1);
      if (inst_valid) begin
        chk("pc", pc, m_pc);
        chk("inst", inst, aligned ? mem_word(m_pc) : NOP);
        chk("misaligned_flag", inst_misaligned, !aligned);
      end
      cons = inst_valid && inst_ready;
      if (cons) begin
        m_pc = pc_next; m_hs = 0; m_since = 0; m_await = 1'b0;
      end
      p_consume = cons; p_req_v = imem_req_valid; p_req_r = imem_req_ready;
      p_iv = inst_valid; p_ir = inst_ready; p_rsp_ok = rsp_ok;
    end
  end

  // ---------------- memory and decode stimulus models ----------------
  bit          m_fast = 1'b1, auto_dec = 1'b0;
  int          m_lat_cfg = 0;
  int unsigned m_stall = 0, m_stale = 0;
  bit          mb_busy = 1'b0, mb_pend = 1'b0;
  int unsigned mb_cnt = 0;
  logic [31:0] mb_addr = '0;

  task automatic mem_step();
    bit stale;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mb_pend) begin
      mb_pend = 1'b0;
      mb_busy = 1'b1;
      mb_cnt  = (m_lat_cfg < 0) ? $urandom_range(0, 3) : m_lat_cfg;
    end
    if (mb_busy) begin
      if (mb_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mb_addr);
        mb_busy = 1'b0;
      end else mb_cnt--;
    end
    stale = (m_stale > 0);
    if (stale) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      m_stale--;
    end
    imem_req_ready = 1'b0;
    if (!stale && imem_req_valid && !mb_busy) begin
      if (m_stall > 0) m_stall--;
      else if (m_fast || $urandom_range(0, 2) != 0) begin
        imem_req_ready = 1'b1;
        mb_pend = 1'b1;
        mb_addr = imem_addr;
      end
    end else if (!stale && !m_fast) begin
      imem_req_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic dec_step();
    int unsigned r;
    r = $urandom_range(0, 9);
    inst_ready = inst_valid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
    if (r < 5)      pc_next = pc + 32'd4;
    else if (r < 8) pc_next = $urandom & 32'hFFFF_FFFC;
    else if (r == 8) pc_next = $urandom;
    else            pc_next = 32'hFFFF_FFFC;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    mem_step();
    if (auto_dec) dec_step();
  endtask

  task automatic wait_iv(input string what);
    for (int i = 0; i < 50 && !inst_valid; i++) cycle();
    if (!inst_valid) begin
      n_checks++; n_errors++;
      $display("FAIL timeout_%s: inst_valid got 0 expected 1", what);
    end
  endtask

  task automatic wait_req(input string what);
    for (int i = 0; i < 50 && !imem_req_valid; i++) cycle();
    if (!imem_req_valid) begin
      n_checks++; n_errors++;
      $display("FAIL timeout_%s: imem_req_valid got 0 expected 1", what);
    end
  endtask

  task automatic consume(input logic [31:0] nxt);
    inst_ready = 1'b1;
    pc_next    = nxt;
    cycle();
    inst_ready = 1'b0;
    pc_next    = $urandom;
  endtask

  // ---------------- directed sequence then random soak ----------------
  initial begin
    int unsigned n_req;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", inst, NOP);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_misaligned", inst_misaligned, 1'b0);
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    rst_n = 1'b1;

    wait_iv("first");
    chk("first_inst", inst, 32'h0050_0093);
    chk("first_pc", pc, 32'h0);

    m_stall = 5;
    consume(32'h4);
    chk("second_addr", imem_addr, 32'h4);
    n_req = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid) n_req++;
      if (imem_req_valid && imem_req_ready) break;
      cycle();
    end
    chk("stall_req_cycles", n_req, 6);

    wait_iv("held");
    for (int i = 0; i < 4; i++) begin
      pc_next = i[0] ? 32'h200 : 32'h100;
      cycle();
    end
    chk("held_pc", pc, 32'h4);
    chk("held_inst", inst, 32'h5A5A_0F0B);
    consume(32'h200);
    wait_req("redirect_200");
    chk("addr_200", imem_addr, 32'h200);

    wait_iv("before_mtvec");
    consume(32'h8000_0000);
    chk("mtvec_pc", pc, 32'h8000_0000);
    wait_req("mtvec");
    chk("mtvec_addr", imem_addr, 32'h8000_0000);

    wait_iv("before_misaligned");
    consume(32'h102);
    wait_iv("misaligned");
    chk("misaligned_inst", inst, 32'h0000_0013);
    chk("misaligned_set", inst_misaligned, 1'b1);
    chk("misaligned_pc", pc, 32'h102);

    m_lat_cfg = 8;
    consume(32'h40);
    for (int i = 0; i < 20 && !mb_busy; i++) cycle();
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    mb_busy = 1'b0; mb_pend = 1'b0; m_stale = 0;
    #1;
    chk("midwait_rst_req", imem_req_valid, 1'b0);
    chk("midwait_rst_pc", pc, RST_PC);
    chk("midwait_rst_valid", inst_valid, 1'b0);
    cycle();
    cycle();
    rst_n = 1'b1;
    m_lat_cfg = 0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    imem_req_ready = 1'b0;
    m_stale = 1;
    wait_iv("post_reset");
    chk("post_reset_inst", inst, 32'h0050_0093);
    chk("post_reset_pc", pc, 32'h0);

    m_fast = 1'b0;
    m_lat_cfg = -1;
    auto_dec = 1'b1;
    repeat (2000) cycle();
    auto_dec = 1'b0;
    inst_ready = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
